debug_uart_reporter: RTL and testbench
======================================

Name: debug_uart_reporter

Overview:
- Return-path half of the debug unit. The host loads and runs the pipeline over UART RX; this block reports the result back over UART TX.
- On a start pulse it transmits one fixed frame of 133 bytes: a header byte, the final PC, and all 32 GPRs, each 32-bit word sent MSB-first.
- It drives o_tx, 8N1, LSB-first within each byte, idle high.
- It sits between the halted datapath (PC plus a register-file debug read port) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 10416: clocks per UART bit (100 MHz / 9600 bps). The bench overrides it to 4.
- NB_DATA, 32: width of the PC and of each register word.
- N_REGS, 32: number of registers reported.
- HEADER, 8'h64: frame header byte ('d').

Ports:
- i_clk, in, 1: single clock, rising edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_start, in, 1: one-cycle request to send a frame. Honoured only in IDLE.
- i_pc, in, NB_DATA: final PC. Sampled once, in the cycle i_start is accepted.
- o_reg_addr, out, 5: debug read address to the register file.
- i_reg_data, in, NB_DATA: combinational read data for o_reg_addr.
- o_tx, out, 1: UART serial output.
- o_busy, out, 1: high from start acceptance until o_done.
- o_done, out, 1: one-cycle pulse after the stop bit of the last byte.

Behaviour:
- Reset (asynchronous, i_reset=0) forces all outputs to their reset values:
  - o_tx=1, o_busy=0, o_done=0, o_reg_addr=0.
  - FSM goes to IDLE; all counters are cleared.
- Reset mid-frame aborts the frame. o_tx returns high immediately, with no partial byte completion.
- FSM states: IDLE, LOAD, SEND, WAIT, DONE.
  - IDLE → LOAD when i_start=1. In that cycle, latch i_pc, set word_idx=0 and o_busy=1.
  - LOAD → SEND. Form the next 32-bit word:
    - word_idx=0: PC word, preceded by the header byte.
    - word_idx=1..32: register (word_idx-1).
    - o_reg_addr=word_idx-1 is driven from the cycle before i_reg_data is sampled.
  - SEND → WAIT. Hand the current byte to the serializer: the header first, then word bytes [31:24], [23:16], [15:8], [7:0].
  - WAIT → SEND when the serializer finishes the byte and bytes remain in the word.
  - WAIT → LOAD when the word is finished and word_idx < N_REGS.
  - WAIT → DONE after the last byte of register 31.
  - DONE: assert o_done for one cycle, clear o_busy, then go to IDLE.
- Serializer timing, per byte:
  - start bit 0 for CLKS_PER_BIT clocks;
  - 8 data bits, LSB first, CLKS_PER_BIT clocks each;
  - stop bit 1 for CLKS_PER_BIT clocks.
  - A byte occupies exactly 10*CLKS_PER_BIT clocks.
  - Inter-byte idle gap is at most 2 clocks, spent at o_tx=1.
- Latency:
  - o_tx falls (header start bit) within 3 clocks of i_start acceptance.
  - Whole frame takes 1330*CLKS_PER_BIT clocks, plus at most 2 clocks per byte of gap.
- i_start while o_busy=1 is ignored; there is no queueing. i_start in the same cycle as o_done is also ignored.
- i_pc and i_reg_data changes after sampling have no effect on bytes already latched.
- Counters:
  - baud counter is ceil(log2(CLKS_PER_BIT)) bits and wraps to 0 at CLKS_PER_BIT-1;
  - bit counter is 0..9;
  - byte counter is 0..3;
  - word_idx is 0..N_REGS (6 bits).
  - No counter free-runs in IDLE.

Decomposition:
- Shared debug package holds:
  - header/command byte constants: HEADER 8'h64, plus the RX-side 'l' 8'h6C and 'r' 8'h72;
  - the FSM state enum;
  - the end-of-program marker 32'hFFFFFFFF.
- One sub-module, uart_tx_core, is the byte serializer.
  - Interface: i_clk, i_reset, i_data[7:0], i_valid, o_tx, o_ready.
  - o_ready is high when idle.
  - i_valid with o_ready loads the byte.
  - o_ready rises in the cycle after the stop bit ends.
- The reporter FSM and word/byte sequencing live in debug_uart_reporter.

Test Plan:
1. Reset then idle, with CLKS_PER_BIT=4 → o_tx=1, o_busy=0, o_done=0, o_reg_addr=0 for 100 clocks with no i_start.
2. i_pc=32'h0000000C, regs r1=1, r2=1, r3=2, all others 0, pulse i_start → the bench's UART decoder receives:
   - 64 00 00 00 0C;
   - then 00 00 00 00 (r0), 00 00 00 01 (r1), 00 00 00 01 (r2), 00 00 00 02 (r3);
   - then zeros, 133 bytes in total;
   - o_done pulses once; o_busy is high for the whole frame.
3. Bit timing: header start bit measured → o_tx low for exactly 4 clocks. Header 0x64 shows bit sequence 0,0,0,1,0,0,1,1,0,1 (start, LSB-first data, stop), 40 clocks in all.
4. i_start pulsed again at byte 50 of a frame → no restart. Frame still ends after 133 bytes, with a single o_done.
5. Reset (i_reset=0) during data bit 3 of byte 10 → o_tx=1 and o_busy=0 in the same cycle. A new i_start then produces a full 133-byte frame beginning with 0x64.
6. Register values 32'hDEADBEEF in r31 and 32'hFFFFFFFF in r30 → the final 8 bytes are FF FF FF FF DE AD BE EF, MSB first.

Source files
------------

// File: rtl/debug_uart_reporter_pkg.sv
// Shared debug-unit definitions: protocol bytes, markers and
// the reporter FSM state encoding.
package debug_uart_reporter_pkg;

    localparam logic [7:0]  HEADER_BYTE = 8'h64;
    localparam logic [7:0]  CMD_LOAD    = 8'h6C;
    localparam logic [7:0]  CMD_RUN     = 8'h72;
    localparam logic [31:0] END_MARKER  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } rpt_state_e;

    // Byte idx 0 is the most significant byte of the word.
    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_uart_reporter_tx.sv
// 8N1 byte serializer, LSB first, idle high.
// Accepts a byte whenever o_ready is high and i_valid is set.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_tx,
    output logic       o_ready
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic [8:0]    shreg_q, shreg_d;
    logic [3:0]    bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;

    always_comb begin
        busy_d  = busy_q;
        tx_d    = tx_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        if (!busy_q) begin
            if (i_valid) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shreg_d = {1'b1, i_data};
                bit_d   = 4'd0;
                baud_d  = '0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                // The stop bit falls out of shreg after the 8 data bits.
                bit_d   = bit_q + 4'd1;
                tx_d    = shreg_q[0];
                shreg_d = {1'b1, shreg_q[8:1]};
            end
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            shreg_q <= '1;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = !busy_q;

endmodule

// File: rtl/debug_uart_reporter.sv
// Reports header, final PC and the register file over UART TX
// once the datapath has halted.
module debug_uart_reporter
    import debug_uart_reporter_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 10416,
    parameter int         NB_DATA      = 32,
    parameter int         N_REGS       = 32,
    parameter logic [7:0] HEADER       = HEADER_BYTE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_pc,
    output logic [4:0]         o_reg_addr,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [5:0] LAST_IDX = 6'(N_REGS);

    rpt_state_e         state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic [5:0]         word_idx_q, word_idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               hdr_q, hdr_d;
    logic               word_end_q, word_end_d;
    logic               last_q, last_d;
    logic [4:0]         addr_q, addr_d;

    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        hdr_d      = hdr_q;
        word_end_d = word_end_q;
        last_d     = last_q;
        addr_d     = addr_q;
        tx_valid   = 1'b0;
        tx_data    = hdr_q ? HEADER : word_byte(word_q, byte_cnt_q);
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    pc_d       = i_pc;
                    word_idx_d = '0;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    hdr_d      = 1'b1;
                    word_end_d = 1'b0;
                    last_d     = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                word_d     = (word_idx_q == 6'd0) ? pc_q : i_reg_data;
                byte_cnt_d = '0;
                word_end_d = 1'b0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = ST_WAIT;
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                    end else if (byte_cnt_q == 2'd3) begin
                        word_end_d = 1'b1;
                        if (word_idx_q == LAST_IDX) begin
                            last_d = 1'b1;
                        end else begin
                            // Address moves now so it is stable a cycle before LOAD.
                            word_idx_d = word_idx_q + 6'd1;
                            addr_d     = word_idx_q[4:0];
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            ST_WAIT: begin
                // Next word is fetched while its predecessor's last byte shifts out.
                if (word_end_q && !last_q) begin
                    state_d = ST_LOAD;
                end else if (tx_ready) begin
                    state_d = last_q ? ST_DONE : ST_SEND;
                end
            end
            ST_DONE: begin
                word_idx_d = '0;
                addr_d     = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            hdr_q      <= 1'b0;
            word_end_q <= 1'b0;
            last_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            hdr_q      <= hdr_d;
            word_end_q <= word_end_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_data (tx_data),
        .i_valid(tx_valid),
        .o_tx   (o_tx),
        .o_ready(tx_ready)
    );

    assign o_reg_addr = addr_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_uart_reporter.sv
// Frame-level bench: UART decoder feeding a byte scoreboard,
// table-driven frames plus timing and reset corner cases.
module tb_debug_uart_reporter;

    localparam int CPB          = 4;
    localparam int FRAME_BYTES  = 133;
    localparam int FRAME_BUDGET = 8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_pc;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    assign reg_data = regs[reg_addr];

    always #5 clk = ~clk;

    debug_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .NB_DATA     (32),
        .N_REGS      (32),
        .HEADER      (8'h64)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_start   (i_start),
        .i_pc      (i_pc),
        .o_reg_addr(reg_addr),
        .i_reg_data(reg_data),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_done    (done)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    int          rx_cnt   = 0;
    int          done_cnt = 0;
    logic        dec_act  = 1'b0;
    int          dec_c    = 0;
    logic [9:0]  dec_bits = '0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] r1, r2, r3, r30, r31;
        int          restart_at;
        bit          start_on_done;
    } frame_vec_t;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Receiver: start detected at offset 0, each bit sampled mid-cell.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_act <= 1'b0;
            dec_c   <= 0;
        end else if (!dec_act) begin
            if (tx == 1'b0) begin
                dec_act <= 1'b1;
                dec_c   <= 1;
            end
        end else begin
            dec_c <= dec_c + 1;
            if (dec_c % CPB == CPB / 2)
                dec_bits[dec_c / CPB] <= tx;
            if (dec_c == 10 * CPB - 1) begin
                dec_act <= 1'b0;
                rx_cnt  <= rx_cnt + 1;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_byte", {24'h0, dec_bits[8:1]}, 32'h0);
                end else begin
                    check(dec_bits == {1'b1, exp_q[0], 1'b0}, "rx_frame",
                          {22'h0, dec_bits}, {22'h0, 1'b1, exp_q[0], 1'b0});
                    exp_q.delete(0);
                end
            end
        end
    end

    always @(negedge clk)
        if (done) done_cnt <= done_cnt + 1;

    task automatic push_expected(input logic [31:0] pc);
        logic [31:0] w;
        exp_q.push_back(8'h64);
        for (int k = 0; k <= 32; k++) begin
            w = (k == 0) ? pc : regs[k-1];
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic start_frame(input logic [31:0] pc, output int base, output int dbase);
        push_expected(pc);
        base  = rx_cnt;
        dbase = done_cnt;
        @(negedge clk);
        i_pc    = pc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_pc    = ~pc;
    endtask

    task automatic finish_frame(input int base, input int dbase,
                                input int restart_at, input bit start_on_done);
        bit busy_ok   = 1'b1;
        bit seen      = 1'b0;
        bit pulsed    = 1'b0;
        bit late_busy = 1'b0;
        for (int cyc = 0; cyc < FRAME_BUDGET && !seen; cyc++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (restart_at > 0 && !pulsed && rx_cnt - base == restart_at) begin
                    i_start = 1'b1;
                    pulsed  = 1'b1;
                end
                @(negedge clk);
                i_start = 1'b0;
            end
        end
        if (restart_at > 0)
            check(pulsed, "restart_pulse_issued", 32'(pulsed), 32'h1);
        check(seen, "done_seen", 32'(seen), 32'h1);
        check(busy_ok, "busy_whole_frame", 32'(busy_ok), 32'h1);
        if (start_on_done) i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (60) begin
            if (busy || done) late_busy = 1'b1;
            @(negedge clk);
        end
        check(!late_busy, "idle_after_done", 32'(late_busy), 32'h0);
        check(done_cnt - dbase == 1, "single_done", 32'(done_cnt - dbase), 32'h1);
        check(rx_cnt - base == FRAME_BYTES, "byte_count",
              32'(rx_cnt - base), 32'(FRAME_BYTES));
        check(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic set_regs(input frame_vec_t v);
        for (int k = 0; k < 32; k++) regs[k] = 32'h0;
        regs[1]  = v.r1;
        regs[2]  = v.r2;
        regs[3]  = v.r3;
        regs[30] = v.r30;
        regs[31] = v.r31;
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_vec_t vecs[3];
        int         base, dbase, n;
        bit         idle_ok, found;
        logic       samp [40];
        logic [9:0] hdr_bits;

        vecs[0] = '{32'h0000_000C, 32'h1, 32'h1, 32'h2, 32'h0, 32'h0, 0, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'h0, 32'h0, 32'h0,
                    32'hFFFF_FFFF, 32'hDEAD_BEEF, 50, 1'b1};
        vecs[2] = '{32'h8000_0004, 32'hA5A5_5A5A, 32'h0, 32'h1234_5678,
                    32'h0, 32'h8000_0001, 0, 1'b0};

        rst_n   = 1'b0;
        i_start = 1'b0;
        i_pc    = 32'h0;
        for (int k = 0; k < 32; k++) regs[k] = 32'h0;
        repeat (3) @(negedge clk);
        check(tx == 1'b1, "reset_tx", 32'(tx), 32'h1);
        check(busy == 1'b0, "reset_busy", 32'(busy), 32'h0);
        check(done == 1'b0, "reset_done", 32'(done), 32'h0);
        check(reg_addr == 5'd0, "reset_reg_addr", 32'(reg_addr), 32'h0);

        rst_n   = 1'b1;
        idle_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || reg_addr !== 5'd0)
                idle_ok = 1'b0;
        end
        check(idle_ok, "idle_100_clocks", 32'(idle_ok), 32'h1);
        check(rx_cnt == 0, "idle_no_bytes", 32'(rx_cnt), 32'h0);

        for (int v = 0; v < 3; v++) begin
            set_regs(vecs[v]);
            start_frame(vecs[v].pc, base, dbase);
            finish_frame(base, dbase, vecs[v].restart_at, vecs[v].start_on_done);
        end

        // Header bit timing, measured cell by cell.
        for (int k = 0; k < 32; k++) regs[k] = 32'h0;
        start_frame(32'h0000_0040, base, dbase);
        n = 1;
        while (tx && n < 3) begin
            @(negedge clk);
            n++;
        end
        check(!tx, "start_latency", 32'(n), 32'h3);
        for (int s = 0; s < 40; s++) begin
            samp[s] = tx;
            @(negedge clk);
        end
        hdr_bits = 10'b1_0110_0100_0;
        for (int b = 0; b < 10; b++) begin
            check(samp[4*b] == hdr_bits[b] && samp[4*b+1] == hdr_bits[b] &&
                  samp[4*b+2] == hdr_bits[b] && samp[4*b+3] == hdr_bits[b],
                  "header_bit_cell",
                  {28'h0, samp[4*b], samp[4*b+1], samp[4*b+2], samp[4*b+3]},
                  {28'h0, {4{hdr_bits[b]}}});
        end
        finish_frame(base, dbase, 0, 1'b0);

        // Abort during data bit 3 of byte 10, then a clean frame.
        start_frame(32'h0000_0ABC, base, dbase);
        found = 1'b0;
        for (int cyc = 0; cyc < FRAME_BUDGET && !found; cyc++) begin
            @(negedge clk);
            #1;
            if (rx_cnt - base == 10 && dec_act && dec_c == 4 * CPB + 2)
                found = 1'b1;
        end
        check(found, "reached_byte10_bit3", 32'(rx_cnt - base), 32'd10);
        check(tx == 1'b0, "pre_reset_tx_low", 32'(tx), 32'h0);
        rst_n = 1'b0;
        #1;
        check(tx == 1'b1, "abort_tx_high", 32'(tx), 32'h1);
        check(busy == 1'b0, "abort_busy_low", 32'(busy), 32'h0);
        check(done == 1'b0, "abort_no_done", 32'(done), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        regs[5] = 32'h0102_0304;
        start_frame(32'h0000_0DEF, base, dbase);
        finish_frame(base, dbase, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
